// File: rtl/led_code_pkg.sv
// Shared code/time definitions for the error collector and the LED blinker.
// Both blocks use the same cycle conversions so their timing math agrees.
package led_code_pkg;

    localparam int unsigned NO_ERROR_CODE = 0;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_e;

    // Conversions clamp to 1 so a zero-length interval still costs one cycle.
    function automatic int unsigned us_to_cycles(input int unsigned us, input int unsigned freq_hz);
        int unsigned c;
        c = us * (freq_hz / 1_000_000);
        return (c < 1) ? 1 : c;
    endfunction

    function automatic int unsigned ms_to_cycles(input int unsigned ms, input int unsigned freq_hz);
        int unsigned c;
        c = ms * (freq_hz / 1000);
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/err_filter.sv
// One error flag: 2-flop synchroniser followed by a persistence counter.
// qualified is high while the synced flag has been high for FILTER_CYCLES samples.
module err_filter
    import led_code_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic flag_in,
    output logic qualified
);

    localparam logic [31:0] COUNT_MAX = 32'(FILTER_CYCLES - 1);

    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic [31:0] count_q, count_d;

    always_comb begin
        sync1_d = flag_in;
        sync2_d = sync1_q;
        count_d = '0;
        if (sync2_q) begin
            count_d = (count_q == COUNT_MAX) ? count_q : count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            count_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            count_q <= count_d;
        end
    end

    assign qualified = sync2_q & (count_q == COUNT_MAX);

endmodule

// File: rtl/error_code_collector.sv
// Filters and latches error flags as sticky bits, then presents them one at a
// time as numeric codes (source i -> i+1), rotating round-robin with a minimum hold.
module error_code_collector
    import led_code_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ    = 50_000_000,
    parameter int unsigned SOURCES_COUNT = 8,
    parameter int unsigned BITS_COUNT    = 8,
    parameter int unsigned FILTER_US     = 100,
    parameter int unsigned HOLD_MS       = 3_000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [SOURCES_COUNT-1:0] err_flags,
    input  logic [SOURCES_COUNT-1:0] err_mask,
    input  logic                     clear,
    output logic [BITS_COUNT-1:0]    error_code,
    output logic                     error_valid,
    output logic [SOURCES_COUNT-1:0] error_sticky
);

    localparam int unsigned FILTER_CYCLES = us_to_cycles(FILTER_US, CLOCK_FREQ);
    localparam int unsigned HOLD_CYCLES   = ms_to_cycles(HOLD_MS, CLOCK_FREQ);
    localparam logic [31:0] HOLD_LAST     = 32'(HOLD_CYCLES - 1);

    // First pending source at or after index start (wrapping), as a code; 0 if none.
    function automatic logic [BITS_COUNT-1:0] rr_next_code(
        input logic [SOURCES_COUNT-1:0] pend,
        input int unsigned              start
    );
        logic [BITS_COUNT-1:0] code;
        logic                  found;
        int unsigned           j;
        code  = BITS_COUNT'(NO_ERROR_CODE);
        found = 1'b0;
        for (int unsigned k = 0; k < SOURCES_COUNT; k++) begin
            j = start + k;
            if (j >= SOURCES_COUNT) begin
                j = j - SOURCES_COUNT;
            end
            if (!found && pend[j]) begin
                found = 1'b1;
                code  = BITS_COUNT'(j + 1);
            end
        end
        return code;
    endfunction

    logic [SOURCES_COUNT-1:0] qualified;
    logic [SOURCES_COUNT-1:0] sticky_q, sticky_d;
    state_e                   state_q, state_d;
    logic [BITS_COUNT-1:0]    code_q, code_d;
    logic                     valid_q, valid_d;
    logic [31:0]              timer_q, timer_d;
    logic [BITS_COUNT-1:0]    next_code;
    int unsigned              search_start;

    for (genvar i = 0; i < SOURCES_COUNT; i++) begin : g_filter
        err_filter #(
            .FILTER_CYCLES(FILTER_CYCLES)
        ) u_filter (
            .clk      (clk),
            .reset    (reset),
            .flag_in  (err_flags[i]),
            .qualified(qualified[i])
        );
    end

    // A new qualification in the same cycle as clear survives.
    always_comb begin
        sticky_d = ({SOURCES_COUNT{~clear}} & sticky_q) | (qualified & ~err_mask);
    end

    // Current code c belongs to index c-1, so the search starts at index c.
    always_comb begin
        search_start = (state_q == SHOW) ? int'(code_q) : 0;
        next_code    = rr_next_code(sticky_q, search_start);
        state_d      = state_q;
        code_d       = code_q;
        valid_d      = valid_q;
        timer_d      = timer_q;
        case (state_q)
            IDLE: begin
                code_d  = BITS_COUNT'(NO_ERROR_CODE);
                valid_d = 1'b0;
                if (next_code != BITS_COUNT'(NO_ERROR_CODE)) begin
                    code_d  = next_code;
                    valid_d = 1'b1;
                    timer_d = '0;
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (timer_q == HOLD_LAST) begin
                    timer_d = '0;
                    if (next_code != BITS_COUNT'(NO_ERROR_CODE)) begin
                        code_d  = next_code;
                        valid_d = 1'b1;
                    end else begin
                        code_d  = BITS_COUNT'(NO_ERROR_CODE);
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
                code_d  = BITS_COUNT'(NO_ERROR_CODE);
                valid_d = 1'b0;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky_q <= '0;
            state_q  <= IDLE;
            code_q   <= '0;
            valid_q  <= 1'b0;
            timer_q  <= '0;
        end else begin
            sticky_q <= sticky_d;
            state_q  <= state_d;
            code_q   <= code_d;
            valid_q  <= valid_d;
            timer_q  <= timer_d;
        end
    end

    assign error_code   = code_q;
    assign error_valid  = valid_q;
    assign error_sticky = sticky_q;

endmodule

// File: tb/tb_error_code_collector.sv
// Directed bench for error_code_collector: filter=3 cycles, hold=1000 cycles.
`timescale 1ns/1ps
module tb_error_code_collector;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] err_flags = '0;
    logic [7:0] err_mask = '0;
    logic       clear = 1'b0;
    logic [7:0] error_code;
    logic       error_valid;
    logic [7:0] error_sticky;

    int checks = 0;
    int errors = 0;

    error_code_collector #(
        .CLOCK_FREQ   (1_000_000),
        .SOURCES_COUNT(8),
        .BITS_COUNT   (8),
        .FILTER_US    (3),
        .HOLD_MS      (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .err_flags   (err_flags),
        .err_mask    (err_mask),
        .clear       (clear),
        .error_code  (error_code),
        .error_valid (error_valid),
        .error_sticky(error_sticky)
    );

    always #500 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        err_flags = '0;
        err_mask = '0;
        clear = 1'b0;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    // Cycles until error_code leaves its current value, capped at 2000.
    task automatic measure_hold(input logic [7:0] code, output int held);
        held = 0;
        while (error_code == code && held < 2000) begin
            step(1);
            held++;
        end
    endtask

    int          held;
    logic [7:0]  seq [5];

    initial begin
        // Reset state
        do_reset();
        check("rst_code", error_code, 0);
        check("rst_valid", error_valid, 0);
        check("rst_sticky", error_sticky, 0);

        // 1. Glitch rejection, then exact latency
        err_flags[2] = 1'b1;
        step(2);
        err_flags[2] = 1'b0;
        step(10);
        check("glitch_sticky", error_sticky, 8'h00);
        check("glitch_code", error_code, 0);
        err_flags[2] = 1'b1;
        step(5);
        check("t1_sticky_e5", error_sticky, 8'h04);
        check("t1_code_e5", error_code, 0);
        step(1);
        check("t1_code_e6", error_code, 3);
        check("t1_valid_e6", error_valid, 1);

        // 2. Single error held exactly 1000 cycles, cleared mid-hold
        do_reset();
        err_flags[0] = 1'b1;
        step(6);
        check("t2_code", error_code, 1);
        err_flags[0] = 1'b0;
        held = 0;
        while (error_code == 8'd1 && held < 2000) begin
            if (held == 500) clear = 1'b1;
            step(1);
            clear = 1'b0;
            held++;
            if (held == 501) check("t2_sticky_clr", error_sticky, 0);
        end
        check("t2_hold", held, 1000);
        check("t2_code_end", error_code, 0);
        check("t2_valid_end", error_valid, 0);

        // 3. Round-robin across sources 1, 4, 6
        do_reset();
        err_flags = 8'h52;
        step(6);
        err_flags = 8'h00;
        check("t3_sticky", error_sticky, 8'h52);
        check("t3_code0", error_code, 2);
        seq[0] = 8'd2; seq[1] = 8'd5; seq[2] = 8'd7; seq[3] = 8'd2; seq[4] = 8'd5;
        for (int k = 0; k < 4; k++) begin
            measure_hold(seq[k], held);
            check($sformatf("t3_hold%0d", k), held, 1000);
            check($sformatf("t3_code%0d", k + 1), error_code, seq[k + 1]);
        end

        // 4. Masking blocks new sets only
        do_reset();
        err_mask = 8'h08;
        err_flags[3] = 1'b1;
        step(20);
        check("t4_masked_sticky", error_sticky, 0);
        check("t4_masked_code", error_code, 0);
        err_mask = 8'h00;
        step(1);
        check("t4_unmask_sticky", error_sticky, 8'h08);
        step(1);
        check("t4_unmask_code", error_code, 4);
        err_mask = 8'h08;
        err_flags[3] = 1'b0;
        step(20);
        check("t4_sticky_kept", error_sticky, 8'h08);

        // 5. Clear coinciding with qualification of source 5
        do_reset();
        err_flags[2] = 1'b1;
        step(6);
        err_flags[2] = 1'b0;
        step(4);
        check("t5_pre_sticky", error_sticky, 8'h04);
        err_flags[5] = 1'b1;
        step(4);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check("t5_set_wins", error_sticky, 8'h20);
        err_flags[5] = 1'b0;

        // 6. Asynchronous reset while showing code 3
        do_reset();
        err_flags[2] = 1'b1;
        step(6);
        err_flags[2] = 1'b0;
        step(100);
        check("t6_code_show", error_code, 3);
        @(posedge clk);
        #200;
        reset = 1'b1;
        #1;
        check("t6_async_code", error_code, 0);
        check("t6_async_valid", error_valid, 0);
        check("t6_async_sticky", error_sticky, 0);
        step(2);
        reset = 1'b0;
        step(50);
        check("t6_after_code", error_code, 0);
        check("t6_after_valid", error_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
